// File: rtl/pipeline_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a
// two-entry skid buffer, synchronous flush and saturating stall counter.
module pipeline_stage_skid #(
  parameter int unsigned CW   = 4,
  parameter int unsigned DW   = 32,
  parameter int unsigned NCH  = 3,
  parameter int unsigned RW   = 5,
  parameter int unsigned CNTW = 16,
  parameter bit ZERO_CTRL_ON_BUBBLE = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_control,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [RW-1:0]     in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_control,
  output logic [NCH*DW-1:0] out_data,
  output logic [RW-1:0]     out_rd,
  output logic [CNTW-1:0]   stall_count
);

  // Encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]     m_ctrl_q, m_ctrl_d;
  logic [NCH*DW-1:0] m_data_q, m_data_d;
  logic [RW-1:0]     m_rd_q, m_rd_d;
  logic [CW-1:0]     s_ctrl_q, s_ctrl_d;
  logic [NCH*DW-1:0] s_data_q, s_data_d;
  logic [RW-1:0]     s_rd_q, s_rd_d;
  logic [CNTW-1:0]   stall_q, stall_d;

  logic main_v, skid_v;
  logic acc, drn;

  assign main_v = state_q[0];
  assign skid_v = state_q[1];
  assign acc    = in_valid & ~skid_v;
  assign drn    = main_v & out_ready;

  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    m_rd_d   = m_rd_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    s_rd_d   = s_rd_q;
    stall_d  = stall_q;

    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          m_ctrl_d = in_control;
          m_data_d = in_data;
          m_rd_d   = in_rd;
          state_d  = ONE;
        end
      end
      ONE: begin
        if (acc && drn) begin
          m_ctrl_d = in_control;
          m_data_d = in_data;
          m_rd_d   = in_rd;
        end else if (acc) begin
          s_ctrl_d = in_control;
          s_data_d = in_data;
          s_rd_d   = in_rd;
          state_d  = TWO;
        end else if (drn) begin
          state_d  = EMPTY;
        end
      end
      TWO: begin
        if (drn) begin
          m_ctrl_d = s_ctrl_q;
          m_data_d = s_data_q;
          m_rd_d   = s_rd_q;
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (flush) begin
      state_d  = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end

    // Counts even in a flush cycle; only reset clears it.
    if (main_v && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNTW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= EMPTY;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      m_rd_q   <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
      s_rd_q   <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      m_rd_q   <= m_rd_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
      s_rd_q   <= s_rd_d;
      stall_q  <= stall_d;
    end
  end

  assign in_ready    = ~skid_v;
  assign out_valid   = main_v;
  assign out_control = (ZERO_CTRL_ON_BUBBLE && !main_v) ? '0 : m_ctrl_q;
  assign out_data    = m_data_q;
  assign out_rd      = m_rd_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Bench for pipeline_stage_skid: directed plan steps then random traffic,
// checked against a depth-2 FIFO reference model.
module tb_pipeline_stage_skid;

  localparam int CW   = 4;
  localparam int DW   = 32;
  localparam int NCH  = 3;
  localparam int RW   = 5;
  localparam int CNTW = 4;
  localparam int SMAX = (1 << CNTW) - 1;

  typedef struct {
    logic [CW-1:0]     c;
    logic [NCH*DW-1:0] d;
    logic [RW-1:0]     r;
  } beat_t;

  logic              clock;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CW-1:0]     in_control;
  logic [NCH*DW-1:0] in_data;
  logic [RW-1:0]     in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_control;
  logic [NCH*DW-1:0] out_data;
  logic [RW-1:0]     out_rd;
  logic [CNTW-1:0]   stall_count;

  int n_assert = 0;
  int n_fail   = 0;

  beat_t      mq[$];
  int         mcnt = 0;
  logic [RW-1:0] drained[$];

  pipeline_stage_skid #(
    .CW(CW), .DW(DW), .NCH(NCH), .RW(RW), .CNTW(CNTW),
    .ZERO_CTRL_ON_BUBBLE(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_control(in_control),
    .in_data(in_data),
    .in_rd(in_rd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_control(out_control),
    .out_data(out_data),
    .out_rd(out_rd),
    .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v,
                      input logic [CW-1:0] c,
                      input logic [NCH*DW-1:0] d,
                      input logic [RW-1:0] r,
                      input logic ordy,
                      input logic fl,
                      input logic rst);
    bit mv;
    bit mir;
    beat_t b;
    in_valid   = v;
    in_control = c;
    in_data    = d;
    in_rd      = r;
    out_ready  = ordy;
    flush      = fl;
    reset      = rst;
    @(posedge clock);
    mv  = (mq.size() > 0);
    mir = (mq.size() < 2);
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (mv && !ordy && mcnt != SMAX) mcnt++;
      if (fl) begin
        mq.delete();
      end else begin
        if (mv && ordy) begin
          drained.push_back(mq[0].r);
          void'(mq.pop_front());
        end
        if (v && mir) begin
          b.c = c;
          b.d = d;
          b.r = r;
          mq.push_back(b);
        end
      end
    end
    #1;
    check("out_valid", 128'(out_valid), 128'(mq.size() > 0));
    check("in_ready", 128'(in_ready), 128'(mq.size() < 2));
    check("stall_count", 128'(stall_count), 128'(mcnt));
    check("legal_state", 128'(in_ready | out_valid), 128'(1));
    if (mq.size() > 0) begin
      check("out_control", 128'(out_control), 128'(mq[0].c));
      check("out_data", 128'(out_data), 128'(mq[0].d));
      check("out_rd", 128'(out_rd), 128'(mq[0].r));
    end else begin
      check("bubble_ctrl", 128'(out_control), 128'(0));
    end
    if (rst) begin
      check("rst_data", 128'(out_data), 128'(0));
      check("rst_rd", 128'(out_rd), 128'(0));
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic [RW-1:0] r, input logic ordy);
    step(1'b1, CW'(r), {NCH{DW'(r)}}, r, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    int held;
    logic [CW-1:0] rc;
    logic [NCH*DW-1:0] rd_data;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_control = '0; in_data = '0; in_rd = '0;

    // 1: reset and fill
    step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    check("t1_ctrl_zero", 128'(out_control), 128'(0));
    step(1'b1, 4'hA, {32'h3, 32'h2, 32'h1}, 5'd7, 1'b1, 1'b0, 1'b0);
    check("t1_valid", 128'(out_valid), 128'(1));
    check("t1_ctrl", 128'(out_control), 128'(4'hA));
    check("t1_ch0", 128'(out_data[31:0]), 128'(32'h1));
    check("t1_ch1", 128'(out_data[63:32]), 128'(32'h2));
    check("t1_ch2", 128'(out_data[95:64]), 128'(32'h3));
    check("t1_rd", 128'(out_rd), 128'(7));

    // 2: streaming
    for (int i = 1; i <= 8; i++) begin
      beat(RW'(i), 1'b1);
      check("t2_rd", 128'(out_rd), 128'(i));
      check("t2_ready", 128'(in_ready), 128'(1));
    end
    idle(1'b1);
    check("t2_stall", 128'(stall_count), 128'(0));

    // 3: back-pressure into skid
    step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    drained.delete();
    beat(5'd1, 1'b1);
    beat(5'd2, 1'b0);
    check("t3_skid_full", 128'(in_ready), 128'(0));
    beat(5'd3, 1'b0);
    beat(5'd3, 1'b0);
    beat(5'd3, 1'b1);
    beat(5'd3, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("t3_count", 128'(drained.size()), 128'(3));
    if (drained.size() == 3) begin
      check("t3_ord0", 128'(drained[0]), 128'(1));
      check("t3_ord1", 128'(drained[1]), 128'(2));
      check("t3_ord2", 128'(drained[2]), 128'(3));
    end
    check("t3_stall", 128'(stall_count), 128'(3));

    // 4: flush from TWO
    beat(5'd4, 1'b0);
    beat(5'd5, 1'b0);
    check("t4_two", 128'(in_ready), 128'(0));
    held = mcnt;
    drained.delete();
    step(1'b1, 4'h9, '1, 5'd9, 1'b1, 1'b1, 1'b0);
    check("t4_valid", 128'(out_valid), 128'(0));
    check("t4_ctrl", 128'(out_control), 128'(0));
    check("t4_ready", 128'(in_ready), 128'(1));
    check("t4_stall", 128'(stall_count), 128'(held));
    idle(1'b1);
    idle(1'b1);
    check("t4_no9", 128'(drained.size()), 128'(0));

    // 5: saturation
    step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    beat(5'd11, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    check("t5_sat", 128'(stall_count), 128'(15));
    idle(1'b0);
    check("t5_hold", 128'(stall_count), 128'(15));

    // 6: reset beats flush
    beat(5'd12, 1'b0);
    check("t6_two", 128'(in_ready), 128'(0));
    step(1'b1, 4'hF, '1, 5'd13, 1'b0, 1'b1, 1'b1);
    check("t6_valid", 128'(out_valid), 128'(0));
    check("t6_ctrl", 128'(out_control), 128'(0));
    check("t6_data", 128'(out_data), 128'(0));
    check("t6_rd", 128'(out_rd), 128'(0));
    check("t6_ready", 128'(in_ready), 128'(1));
    check("t6_stall", 128'(stall_count), 128'(0));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rc = CW'($urandom);
      rd_data = {$urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 3) != 0), rc, rd_data, RW'($urandom),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_skid.md
Name: pipeline_stage_skid

Overview:
Parametrised inter-stage pipeline register for the RISC-V pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle, NCH data channels and a destination-register field. It adds a valid/ready handshake, a two-entry skid buffer, synchronous flush and a saturating stall counter. Stages can therefore back-pressure without combinational ready paths, and the hazard unit can squash in-flight instructions.

Parameters:
CW, 4, control bundle width
DW, 32, width of each data channel
NCH, 3, number of data channels (for example ALU result, write data, PC+4)
RW, 5, destination register index width
CNTW, 16, stall counter width
ZERO_CTRL_ON_BUBBLE, 1, if 1 then out_control reads 0 whenever out_valid=0

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
flush  in  1  squash all held entries (from hazard unit)
in_valid  in  1  upstream beat present
in_ready  out  1  block can accept a beat; registered output
in_control  in  CW  upstream control bundle
in_data  in  NCH*DW  channel k at bits [k*DW +: DW]
in_rd  in  RW  upstream destination register
out_valid  out  1  downstream beat present
out_ready  in  1  downstream accepts
out_control  out  CW  control to next stage
out_data  out  NCH*DW  data to next stage
out_rd  out  RW  destination register to next stage
stall_count  out  CNTW  cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage: main entry (drives the out_* ports) and skid entry. Each entry holds {control, data, rd, valid}.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY: 00
  - ONE: 01
  - TWO: 11
  - The encoding 10 is illegal and never reached.
- in_ready = NOT skid_valid. It comes directly from a flop, with no combinational path from out_ready.
- Accept condition: in_valid AND in_ready. Drain condition: out_valid AND out_ready.
- EMPTY:
  - Accept: beat loads main, go to ONE.
  - Out-to-in latency is 1 cycle.
- ONE:
  - Accept and drain together: main takes the new beat, stay in ONE. Full throughput, 1 beat per cycle.
  - Accept only: beat goes to skid, go to TWO.
  - Drain only: go to EMPTY.
- TWO:
  - No accept is possible (in_ready=0).
  - Drain: skid moves to main, skid clears, go to ONE.
- Ordering: beats leave in arrival order. No beat is duplicated or dropped, except by flush.
- Flush (synchronous, priority over all handshake activity):
  - Both valids clear on the next edge and the state goes to EMPTY.
  - A beat accepted in the flush cycle is discarded.
  - Control fields of both entries load 0. Data and rd fields may hold their old values.
  - in_ready is 1 in the cycle after the flush.
- Bubble: if ZERO_CTRL_ON_BUBBLE=1, out_control is 0 whenever out_valid=0. Downstream therefore never writes the register file or memory from a stale entry.
- Reset (synchronous, priority over flush):
  - All entries, valids and stall_count go to 0.
  - After reset: out_valid=0, out_control=0, out_data=0, out_rd=0, in_ready=1, stall_count=0.
  - Reset in the middle of a transfer discards everything held.
- stall_count:
  - Increments on every edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNTW-1 and never wraps.
  - Cleared only by reset; flush does not clear it.
- While out_valid=1 and out_ready=0, out_* remain stable.
- Behaviour with NCH=1 or CW=1 is identical apart from widths.

Test Plan:
1. Reset and fill: assert reset 2 cycles, then in_valid=1 with control=4'hA, data={32'h3,32'h2,32'h1}, rd=5'd7, out_ready=1 → the next cycle shows out_valid=1, out_control=4'hA, out_data ch0=1, ch1=2, ch2=3, out_rd=7. Before that, out_* are all zero.
2. Streaming: 8 back-to-back beats with rd=1..8 and out_ready held at 1 → out_rd reads 1..8 on consecutive cycles, in_ready stays 1, stall_count=0.
3. Back-pressure and skid: stream rd=1,2,3 and drop out_ready in the cycle beat 2 arrives, for 3 cycles → in_ready goes 0 after beat 2 lands in skid and beat 3 is held upstream. After out_ready returns, the output order is 1,2,3 with no loss, and stall_count=3.
4. Flush: with the skid full (TWO), assert flush together with in_valid=1 and rd=9 → next cycle out_valid=0, out_control=0, in_ready=1. Beat 9 never appears, and stall_count keeps its value.
5. Saturation: CNTW=4, out_valid=1, out_ready=0 for 20 cycles → stall_count goes up to 15 and holds at 15.
6. Reset priority: assert reset and flush together in state TWO, with in_valid=1 → all outputs zero and in_ready=1 next cycle. Also assert stall_count=0 and that the illegal state {skid_valid=1, main_valid=0} never occurs.
